// File: rtl/data_memory_mmio.sv
// data_memory_mmio: MEM-stage data memory with a memory-mapped UART window.
//
// Byte-addressed, word-organised RAM with RISC-V B/H/W load/store sizing,
// sign/zero extension and misalignment detection. Three exact-match UART
// addresses take priority over RAM: RX holding register (read), status
// register (read / write-1-to-clear sticky bits) and TX FIFO push (write).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   address, funct3     byte address and RISC-V load/store size code
//   read_enable         load in progress (qualifies the RX-data read clear)
//   write_enable        store
//   data_in / data_out  store data (right-aligned) / extended load result
//   misaligned          access not naturally aligned for funct3
//   uart_tx_*           FIFO head toward the transmitter (valid/ready)
//   uart_rx_*           received byte with one-cycle valid pulse
//
// Build option: define DMEM_SYNC_READ_EN to register data_out
// (1-cycle load latency, read-first on same-word store+load).

module data_memory_mmio #(
    parameter int unsigned             XLEN              = 32,
    parameter int unsigned             DEPTH             = 256,
    parameter int unsigned             TX_FIFO_DEPTH     = 4,
    parameter logic [XLEN-1:0]         UART_RX_DATA_ADDR = 'h650,
    parameter logic [XLEN-1:0]         UART_STATUS_ADDR  = 'h660,
    parameter logic [XLEN-1:0]         UART_TX_ADDR      = 'h680
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] address,
    input  logic [2:0]      funct3,
    input  logic            read_enable,
    input  logic            write_enable,
    input  logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] data_out,
    output logic            misaligned,
    output logic [7:0]      uart_tx_data,
    output logic            uart_tx_valid,
    input  logic            uart_tx_ready,
    input  logic [7:0]      uart_rx_data,
    input  logic            uart_rx_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam int NB = XLEN / 8;

    // ------------------------------------------------------------------
    // Address decode and access sizing
    // ------------------------------------------------------------------
    logic is_rx, is_st, is_tx, is_uart, ram_hit;
    logic is_b, is_h, is_w, is_unsigned;

    assign is_rx   = (address == UART_RX_DATA_ADDR);
    assign is_st   = (address == UART_STATUS_ADDR);
    assign is_tx   = (address == UART_TX_ADDR);
    assign is_uart = is_rx | is_st | is_tx;
    assign ram_hit = (address < XLEN'(DEPTH * 4));

    // funct3[1:0]: 00 byte, 01 half, 1x word (reserved codes fall into word)
    assign is_b        = (funct3[1:0] == 2'b00);
    assign is_h        = (funct3[1:0] == 2'b01);
    assign is_w        = funct3[1];
    assign is_unsigned = funct3[2];

    assign misaligned = (is_h && address[0]) || (is_w && (address[1:0] != 2'b00));

    // ------------------------------------------------------------------
    // RAM (not reset)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   widx;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata;
    logic            ram_we;

    assign widx   = address[AW+1:2];
    assign ram_we = write_enable && !misaligned && ram_hit && !is_uart;

    always_comb begin
        be    = '0;
        wdata = data_in;
        if (is_b) begin
            be    = NB'(1) << address[1:0];
            wdata = {NB{data_in[7:0]}};
        end else if (is_h) begin
            be    = NB'(3) << {address[1], 1'b0};
            wdata = {(NB/2){data_in[15:0]}};
        end else begin
            be    = '1;
            wdata = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    logic [XLEN-1:0] word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ram_rdata;

    assign word     = mem[widx];
    assign byte_sel = word[{address[1:0], 3'b000} +: 8];
    assign half_sel = word[{address[1], 4'b0000} +: 16];

    always_comb begin
        ram_rdata = word;
        if (is_b) begin
            ram_rdata = is_unsigned ? {{(XLEN-8){1'b0}}, byte_sel}
                                    : {{(XLEN-8){byte_sel[7]}}, byte_sel};
        end else if (is_h) begin
            ram_rdata = is_unsigned ? {{(XLEN-16){1'b0}}, half_sel}
                                    : {{(XLEN-16){half_sel[15]}}, half_sel};
        end
    end

    // ------------------------------------------------------------------
    // UART TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo [TX_FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          tx_full, tx_req, tx_push, tx_pop, tx_drop;

    assign tx_full       = (count == CW'(TX_FIFO_DEPTH));
    assign uart_tx_valid = (count != '0);
    assign tx_pop        = uart_tx_valid && uart_tx_ready;
    assign tx_req        = write_enable && !misaligned && is_tx;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign tx_push       = tx_req && (!tx_full || tx_pop);
    assign tx_drop       = tx_req && tx_full && !tx_pop;
    // Gated so the idle/reset value is 0 regardless of stale storage.
    assign uart_tx_data  = uart_tx_valid ? fifo[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (tx_push) fifo[wr_ptr] <= data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + FW'(1);
            if (tx_pop)  rd_ptr <= rd_ptr + FW'(1);
            if (tx_push && !tx_pop)      count <= count + CW'(1);
            else if (tx_pop && !tx_push) count <= count - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // UART RX holding register and sticky status
    // ------------------------------------------------------------------
    logic       rx_full, rx_overrun, tx_overflow;
    logic [7:0] rx_byte;
    logic       rx_read, st_wr;

    // A write with read_enable also high is a write only: no RX clear.
    assign rx_read = read_enable && !write_enable && is_rx && !misaligned;
    assign st_wr   = write_enable && is_st;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full     <= 1'b0;
            rx_byte     <= 8'h00;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (uart_rx_valid) begin
                rx_byte <= uart_rx_data;
                rx_full <= 1'b1;
            end else if (rx_read) begin
                rx_full <= 1'b0;
            end

            // A new event wins over a same-cycle clear so it is never lost.
            if (uart_rx_valid && rx_full && !rx_read) rx_overrun <= 1'b1;
            else if (st_wr && data_in[3])             rx_overrun <= 1'b0;

            if (tx_drop)                  tx_overflow <= 1'b1;
            else if (st_wr && data_in[2]) tx_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [XLEN-1:0] status;
    logic [XLEN-1:0] rdata;

    assign status = {{(XLEN-4){1'b0}}, rx_overrun, tx_overflow, tx_full, rx_full};

    always_comb begin
        rdata = '0;
        if (misaligned)   rdata = '0;
        else if (is_rx)   rdata = {{(XLEN-8){1'b0}}, rx_byte};
        else if (is_st)   rdata = status;
        else if (is_tx)   rdata = '0;
        else if (ram_hit) rdata = ram_rdata;
    end

`ifdef DMEM_SYNC_READ_EN
    always_ff @(posedge clk) begin
        if (rst) data_out <= '0;
        else     data_out <= rdata;
    end
`else
    assign data_out = rdata;
`endif

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
Parametrised successor to the single-cycle core's data memory. It provides byte-addressed, word-organised data RAM with RISC-V load/store sizing (B/H/W, signed/unsigned) and misalignment detection. It also decodes a memory-mapped UART window: a TX FIFO with valid/ready handshake toward the UART transmitter, an RX holding register, and a status register. The block sits in the MEM stage between the ALU address result and the writeback mux.

Parameters:
XLEN, 32, data/address width
DEPTH, 256, RAM depth in XLEN-bit words (power of 2)
TX_FIFO_DEPTH, 4, UART TX FIFO entries (power of 2, >=2)
UART_RX_DATA_ADDR, 'h650, byte address of RX data register (read-only)
UART_STATUS_ADDR, 'h660, byte address of status register
UART_TX_ADDR, 'h680, byte address of TX data register (write-only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
address  in  XLEN  byte address
funct3  in  3  RISC-V load/store funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
read_enable  in  1  load in progress (qualifies RX-data read side effect)
write_enable  in  1  store
data_in  in  XLEN  store data (right-aligned)
data_out  out  XLEN  load result, extended per funct3
misaligned  out  1  access not naturally aligned for funct3 (combinational)
uart_tx_data  out  8  FIFO head byte
uart_tx_valid  out  1  FIFO non-empty
uart_tx_ready  in  1  transmitter accepts head byte
uart_rx_data  in  8  received byte
uart_rx_valid  in  1  one-cycle pulse: uart_rx_data valid

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Reset clears the FIFO pointers and count, rx_full, rx_byte, and the sticky bits. After reset: uart_tx_valid=0 and uart_tx_data=0. RAM contents are not reset; they are zero-initialised at configuration.
- Decode order: the three UART addresses (exact match, any funct3) take priority over RAM. RAM hit when address < DEPTH*4; word index = address[$clog2(DEPTH)+1:2]. All other addresses: writes dropped, reads return 0.
- misaligned=1 for H/HU with address[0]=1, and for W with address[1:0]!=0. On a misaligned access, the store is suppressed and data_out=0. Reserved funct3 values (011, 110, 111) are handled as W.
- RAM store (posedge clk, write_enable, aligned): byte enables come from funct3 and address[1:0]. SB writes data_in[7:0] to the selected lane; SH writes data_in[15:0] to lanes {1,0} or {3,2}; SW writes all lanes. Other lanes are unchanged.
- RAM load, combinational (zero-latency): select the lane(s), then sign-extend (B/H) or zero-extend (BU/HU) to XLEN.
- TX path:
  - A write to UART_TX_ADDR pushes data_in[7:0] if FIFO not full.
  - If the FIFO is full, the byte is dropped and tx_overflow is set (sticky).
  - A pop occurs when uart_tx_valid && uart_tx_ready.
  - Push and pop in the same cycle are both performed, count unchanged; this holds when full, since the pop frees the slot.
  - Pointers wrap modulo TX_FIFO_DEPTH.
  - uart_tx_data = head entry, combinational from storage.
  - Reads of UART_TX_ADDR return 0.
- RX path:
  - On uart_rx_valid: rx_byte<=uart_rx_data and rx_full<=1. If rx_full was already 1 and is not being cleared this cycle, rx_overrun<=1 (sticky) and the new byte overwrites.
  - Load of UART_RX_DATA_ADDR (read_enable=1) returns {24'b0, rx_byte} and clears rx_full next edge.
  - If uart_rx_valid coincides with that read: the current rx_byte is returned, the new byte is latched, rx_full stays 1, no overrun.
- Status read (UART_STATUS_ADDR) = {XLEN-4 zeros, rx_overrun, tx_overflow, tx_full, rx_full} (bits 3..0).
  - Any write to the status address clears the sticky bits where data_in[3:2]=1. Bits 1:0 are read-only.
- Writes to UART_RX_DATA_ADDR are ignored. A write with read_enable also high is treated as a write only.

Optional Feature:
DMEM_SYNC_READ_EN:
- Defined: data_out is registered, giving 1-cycle load latency for block-RAM inference. Address, funct3 and status are sampled at the edge. The RX-data clear side effect is unchanged. data_out resets to 0. A store and a load to the same word in the same cycle return old data (read-first).
- Undefined: combinational read as above.

Test Plan:
- SW 0xDEADBEEF @0x10; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; SB 0x55 @0x11 then LW @0x10 -> 0xDEAD55EF.
- SH @0x11 -> misaligned=1, RAM word unchanged; LW @0x12 -> misaligned=1, data_out=0.
- uart_tx_ready=0, write 0x41..0x45 to 0x680 with TX_FIFO_DEPTH=4 -> status bit1=1, bit2=1, 0x45 dropped. Then ready=1 -> 0x41,0x42,0x43,0x44 in order, valid falls after 4 pops.
- FIFO full with push+pop in the same cycle -> count stays 4, no overflow, new byte emitted last.
- rx_valid pulse 0x5A -> status=0x1; load 0x650 -> 0x5A, status next cycle=0x0. Two pulses with no read -> status bit3=1. Write 0xC to 0x660 -> bits 3:2 cleared.
- Assert rst mid-transfer with 3 bytes queued -> uart_tx_valid=0 next cycle, status=0, RAM contents preserved.
